// File: rtl/ball_motion_ctrl.sv
// Frame-rate ball motion controller: owns the ball centre, latches and arbitrates
// player kicks, reflects off field walls and detects goals through either mouth.
`timescale 1ns/1ps

module ball_motion_ctrl #(
    parameter int X_MIN       = 144,
    parameter int X_MAX       = 783,
    parameter int Y_MIN       = 35,
    parameter int Y_MAX       = 514,
    parameter int RADIUS      = 6,
    parameter int GOAL_Y_LO   = 214,
    parameter int GOAL_Y_HI   = 334,
    parameter int SPEED       = 4,
    parameter int GOAL_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        kick_a,
    input  logic        kick_b,
    input  logic [3:0]  kick_vy_a,
    input  logic [3:0]  kick_vy_b,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic        goal_a,
    output logic        goal_b,
    output logic [1:0]  state
);

    localparam int CX = (X_MIN + X_MAX) / 2;
    localparam int CY = (Y_MIN + Y_MAX) / 2;
    localparam int CW = $clog2(GOAL_FRAMES) + 1;

    localparam logic signed [11:0] X_LO = 12'(X_MIN + RADIUS);
    localparam logic signed [11:0] X_HI = 12'(X_MAX - RADIUS);
    localparam logic signed [11:0] Y_LO = 12'(Y_MIN + RADIUS);
    localparam logic signed [11:0] Y_HI = 12'(Y_MAX - RADIUS);
    localparam logic signed [11:0] M_LO = 12'(GOAL_Y_LO);
    localparam logic signed [11:0] M_HI = 12'(GOAL_Y_HI);
    localparam logic signed [3:0]  SPD  = 4'(SPEED);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        MOVE  = 2'd2,
        GOAL  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [10:0]        x_q, x_d, y_q, y_d;
    logic signed [3:0]  vx_q, vx_d, vy_q, vy_d;
    logic signed [3:0]  cap_vy_a_q, cap_vy_a_d, cap_vy_b_q, cap_vy_b_d;
    logic               pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic               last_b_q, last_b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               goal_a_q, goal_a_d, goal_b_q, goal_b_d;

    logic               accept, take_a, take_b, win_a, win_b, do_move;
    logic signed [3:0]  kvx, kvy, nvx, nvy;
    logic signed [11:0] nx, ny, nx_c, ny_c;
    logic               hit_l, hit_r, in_mouth;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        cap_vy_a_d = cap_vy_a_q;
        cap_vy_b_d = cap_vy_b_q;
        pend_a_d   = pend_a_q;
        pend_b_d   = pend_b_q;
        last_b_d   = last_b_q;
        cnt_d      = cnt_q;
        goal_a_d   = 1'b0;
        goal_b_d   = 1'b0;
        do_move    = 1'b0;

        accept = (state_q == SERVE) || (state_q == MOVE);
        if (accept && kick_a) begin
            pend_a_d   = 1'b1;
            cap_vy_a_d = kick_vy_a;
        end
        if (accept && kick_b) begin
            pend_b_d   = 1'b1;
            cap_vy_b_d = kick_vy_b;
        end
        if (frame_tick) begin
            pend_a_d = 1'b0;
            pend_b_d = 1'b0;
        end

        // A kick arriving with frame_tick counts for that tick.
        take_a = accept && (pend_a_q || kick_a);
        take_b = accept && (pend_b_q || kick_b);
        win_a  = take_a && (!take_b || last_b_q);
        win_b  = take_b && !win_a;

        kvx = vx_q;
        kvy = vy_q;
        if (win_a) begin
            kvx = SPD;
            kvy = kick_a ? kick_vy_a : cap_vy_a_q;
        end else if (win_b) begin
            kvx = -SPD;
            kvy = kick_b ? kick_vy_b : cap_vy_b_q;
        end

        nx   = $signed({1'b0, x_q}) + 12'(kvx);
        ny   = $signed({1'b0, y_q}) + 12'(kvy);
        nvx  = kvx;
        nvy  = kvy;
        ny_c = ny;
        if (ny < Y_LO) begin
            ny_c = Y_LO;
            nvy  = -kvy;
        end else if (ny > Y_HI) begin
            ny_c = Y_HI;
            nvy  = -kvy;
        end

        hit_l    = nx < X_LO;
        hit_r    = nx > X_HI;
        in_mouth = (ny_c >= M_LO) && (ny_c <= M_HI);
        nx_c     = nx;
        if (hit_l) begin
            nx_c = X_LO;
            nvx  = -kvx;
        end else if (hit_r) begin
            nx_c = X_HI;
            nvx  = -kvx;
        end

        case (state_q)
            IDLE:  if (start) state_d = SERVE;
            SERVE: do_move = frame_tick && (win_a || win_b);
            MOVE:  do_move = frame_tick;
            GOAL: begin
                if (frame_tick) begin
                    if (cnt_q == CW'(GOAL_FRAMES - 1)) begin
                        state_d = SERVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_move) begin
            if (win_a || win_b) last_b_d = win_b;
            if ((hit_l || hit_r) && in_mouth) begin
                state_d  = GOAL;
                x_d      = 11'(CX);
                y_d      = 11'(CY);
                vx_d     = '0;
                vy_d     = '0;
                cnt_d    = '0;
                goal_a_d = hit_r;
                goal_b_d = hit_l;
            end else begin
                state_d = MOVE;
                x_d     = 11'(nx_c);
                y_d     = 11'(ny_c);
                vx_d    = nvx;
                vy_d    = nvy;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= 11'(CX);
            y_q        <= 11'(CY);
            vx_q       <= '0;
            vy_q       <= '0;
            cap_vy_a_q <= '0;
            cap_vy_b_q <= '0;
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
            last_b_q   <= 1'b1;
            cnt_q      <= '0;
            goal_a_q   <= 1'b0;
            goal_b_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            cap_vy_a_q <= cap_vy_a_d;
            cap_vy_b_q <= cap_vy_b_d;
            pend_a_q   <= pend_a_d;
            pend_b_q   <= pend_b_d;
            last_b_q   <= last_b_d;
            cnt_q      <= cnt_d;
            goal_a_q   <= goal_a_d;
            goal_b_q   <= goal_b_d;
        end
    end

    assign ball_x = x_q;
    assign ball_y = y_q;
    assign goal_a = goal_a_q;
    assign goal_b = goal_b_q;
    assign state  = state_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed self-checking bench for ball_motion_ctrl: serve, kicks, wall bounce,
// tie arbitration, both goals, goal hold time and reset cancelling a goal pulse.
`timescale 1ns/1ps

module tb_ball_motion_ctrl;

    logic        clk = 1'b0;
    logic        reset, frame_tick, start, kick_a, kick_b;
    logic [3:0]  kick_vy_a, kick_vy_b;
    logic [10:0] ball_x, ball_y;
    logic        goal_a, goal_b;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;

    ball_motion_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .kick_a     (kick_a),
        .kick_b     (kick_b),
        .kick_vy_a  (kick_vy_a),
        .kick_vy_b  (kick_vy_b),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .goal_a     (goal_a),
        .goal_b     (goal_b),
        .state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ball(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(ball_x), x);
        chk({tag, "_y"}, 32'(ball_y), y);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic kick(input logic a, input logic b, input logic [3:0] va, input logic [3:0] vb);
        kick_a    = a;
        kick_b    = b;
        kick_vy_a = va;
        kick_vy_b = vb;
        step();
        kick_a = 1'b0;
        kick_b = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
        kick_a = 1'b0; kick_b = 1'b0; kick_vy_a = '0; kick_vy_b = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_state", 32'(state), 0);
        chk_ball("rst", 463, 274);
        chk("rst_goal_a", 32'(goal_a), 0);
        chk("rst_goal_b", 32'(goal_b), 0);

        // Kick in IDLE is discarded; start enters SERVE; idle ticks keep the ball centred
        kick(1'b1, 1'b0, 4'd3, 4'd0);
        chk("idle_kick_state", 32'(state), 0);
        do_start();
        chk("start_state", 32'(state), 1);
        ticks(3);
        chk("serve_hold_state", 32'(state), 1);
        chk_ball("serve_hold", 463, 274);

        // Serve with A, vy = +2
        kick(1'b1, 1'b0, 4'd2, 4'd0);
        tick();
        chk("serve_kick_state", 32'(state), 2);
        chk_ball("move1", 467, 276);
        tick();
        chk_ball("move2", 471, 278);

        // start outside IDLE has no effect
        do_start();
        chk("start_in_move", 32'(state), 2);

        // Re-kick A with vy = -2, then run to the right wall (not in the mouth)
        kick(1'b1, 1'b0, 4'hE, 4'd0);
        tick();
        chk_ball("rekick", 475, 276);
        ticks(75);
        chk_ball("pre_wall", 775, 126);
        tick();
        chk_ball("wall_clamp", 777, 124);
        chk("wall_state", 32'(state), 2);
        chk("wall_no_goal", 32'(goal_a), 0);
        tick();
        chk_ball("wall_reflect", 773, 122);

        // Reset mid-MOVE, then simultaneous kicks twice: A wins first, B second
        do_reset();
        chk("reset_from_move", 32'(state), 0);
        chk_ball("reset_from_move", 463, 274);
        do_start();
        kick(1'b1, 1'b1, 4'd1, 4'hD);
        tick();
        chk_ball("tie1_a_wins", 467, 275);
        kick(1'b1, 1'b1, 4'd1, 4'hD);
        tick();
        chk_ball("tie2_b_wins", 463, 272);
        tick();
        chk_ball("tie2_coast", 459, 269);

        // B serves straight left into the left mouth
        do_reset();
        do_start();
        kick(1'b0, 1'b1, 4'd0, 4'd0);
        tick();
        chk_ball("b_serve", 459, 274);
        ticks(77);
        chk_ball("pre_goal_b", 151, 274);
        chk("pre_goal_b_pulse", 32'(goal_b), 0);
        tick();
        chk("goal_b_state", 32'(state), 3);
        chk("goal_b_pulse", 32'(goal_b), 1);
        chk("goal_b_no_a", 32'(goal_a), 0);
        chk_ball("goal_b_park", 463, 274);
        step();
        chk("goal_b_pulse_end", 32'(goal_b), 0);

        // Kick during GOAL is dropped; GOAL holds for 60 ticks
        kick(1'b1, 1'b0, 4'd5, 4'd0);
        ticks(59);
        chk("goal_hold_59", 32'(state), 3);
        tick();
        chk("goal_exit_60", 32'(state), 1);
        chk_ball("goal_exit", 463, 274);
        tick();
        chk("no_stale_state", 32'(state), 1);
        chk_ball("no_stale", 463, 274);

        // A kick coinciding with frame_tick counts; A scores through the right mouth
        do_reset();
        do_start();
        kick_a = 1'b1; kick_vy_a = 4'd0;
        tick();
        kick_a = 1'b0;
        chk("same_cycle_kick_state", 32'(state), 2);
        chk_ball("same_cycle_kick", 467, 274);
        ticks(77);
        chk_ball("pre_goal_a", 775, 274);
        tick();
        chk("goal_a_state", 32'(state), 3);
        chk("goal_a_pulse", 32'(goal_a), 1);
        chk("goal_a_no_b", 32'(goal_b), 0);

        // Reset during the goal pulse cancels it
        do_reset();
        chk("reset_cancel_pulse", 32'(goal_a), 0);
        chk("reset_cancel_state", 32'(state), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ball_motion_ctrl.md
# ball_motion_ctrl

Frame-rate motion controller for the game ball. Owns the ball position registers that feed the circular ball renderer's centre inputs (`mem_X`, `mem_Y`), advances the position once per video frame, and reflects the ball off the field walls. It detects goals and arbitrates kick requests from the two players, using round-robin priority when both kick in the same frame. It sits between the player input logic and the VGA pixel pipeline.

## Interface
Parameters:
- `X_MIN`, 144: left field edge, pixel column.
- `X_MAX`, 783: right field edge.
- `Y_MIN`, 35: top field edge, pixel row.
- `Y_MAX`, 514: bottom field edge.
- `RADIUS`, 6: ball radius in pixels. Matches renderer threshold r² ≤ 40.
- `GOAL_Y_LO`, 214: first row of the goal mouth, both sides.
- `GOAL_Y_HI`, 334: last row of the goal mouth.
- `SPEED`, 4: |vx| applied by a kick.
- `GOAL_FRAMES`, 60: frames held in GOAL state.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: reset, synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per frame, issued at the start of vertical blanking.
- `start` in 1: level input; leaves IDLE.
- `kick_a` in 1: player A kick request, one-cycle pulse. Sends the ball toward +x.
- `kick_b` in 1: player B kick request, one-cycle pulse. Sends the ball toward −x.
- `kick_vy_a` in 4: signed vy for A's kick, range −7..+7.
- `kick_vy_b` in 4: signed vy for B's kick, range −7..+7.
- `ball_x` out 11: ball centre column. Connects to renderer `mem_X`.
- `ball_y` out 11: ball centre row. Connects to renderer `mem_Y`.
- `goal_a` out 1: one-cycle pulse; A scored (ball left through the right mouth).
- `goal_b` out 1: one-cycle pulse; B scored (ball left through the left mouth).
- `state` out 2: 0 = IDLE, 1 = SERVE, 2 = MOVE, 3 = GOAL.

## Operation
- Centre position: CX = (X_MIN+X_MAX)/2 = 463, CY = (Y_MIN+Y_MAX)/2 = 274. Integer division.
- Reset values:
  - state = IDLE; ball at (CX, CY); vx = vy = 0.
  - Kick-pending bits cleared; goal_a = goal_b = 0; frame counter = 0.
  - last_winner = B, so A wins the first tie.
- Kick latching:
  - A `kick_x` pulse sets `pend_x` and captures `kick_vy_x`.
  - A later pulse before the next frame_tick overwrites the captured vy.
  - Kicks are accepted only in SERVE and MOVE. In IDLE and GOAL they are discarded.
- FSM, evaluated only on frame_tick except for start:
  - IDLE: `start` = 1 (any cycle) → SERVE.
  - SERVE: ball held at centre. On frame_tick with a pending kick → apply the kick, then perform the move step for that tick → MOVE.
  - MOVE: on frame_tick, apply the winning kick if any, then perform the move step.
  - GOAL: ball parked at centre; vx = vy = 0. Count frame_ticks. At the GOAL_FRAMES-th tick → SERVE.
- Applying a kick:
  - A: vx = +SPEED, vy = kick_vy_a. B: vx = −SPEED, vy = kick_vy_b.
  - Both pending: winner = opposite of last_winner. last_winner is updated on every applied kick.
  - All pending bits clear at every frame_tick.
- Move step:
  - Work in 12-bit signed arithmetic: nx = x+vx, ny = y+vy.
  - Y walls: ny < Y_MIN+RADIUS → ny = Y_MIN+RADIUS, vy = −vy. ny > Y_MAX−RADIUS → ny = Y_MAX−RADIUS, vy = −vy.
  - X walls: nx < X_MIN+RADIUS or nx > X_MAX−RADIUS:
    - If the clamped ny is within [GOAL_Y_LO, GOAL_Y_HI] → goal. Left wall pulses goal_b, right wall pulses goal_a. Go to GOAL with the ball at centre.
    - Otherwise clamp nx to the wall and set vx = −vx.
  - A corner hit reflects both axes in the same step.

## Timing
- Kick pulses and frame_tick in the same cycle: the kick counts for that tick.
- ball_x/ball_y, state and vx/vy update on the clock edge after frame_tick is sampled high (1-cycle latency). They are stable for the rest of the frame.
- goal_x pulses high exactly during the cycle in which state first reads GOAL.
- `start` asserted outside IDLE has no effect.
- `reset` during any state: the next cycle shows reset values, and any pulse in flight is cancelled.

## Test plan
- Reset, then `start`, then 3 frame_ticks with no kick → state = SERVE, ball stays at (463, 274).
- SERVE, kick_a with vy = +2, then 1 frame_tick → state = MOVE, ball (467, 276). Next tick → (471, 278).
- Ball at (775, 100), vx = +4, vy = −2 → after a tick, x clamps to 777, vx = −4; ball (777, 98). The next tick gives (773, 96).
- Ball at (150, 250), vx = −4 → after a tick, goal_b pulses for 1 cycle, state = GOAL, ball at (463, 274). After 60 ticks, state = SERVE.
- kick_a and kick_b pulsed in the same frame, twice in a row → A wins the first frame, B wins the second; vx = +4, then −4.
- kick_a pulsed in GOAL state, then the state returns to SERVE → no stale kick is applied; the ball stays centred.
